multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main controller for the multi-cycle MIPS datapath. It drives the ALU's 3-bit Control input and consumes the ALU's Zero output. The block is a Moore FSM that sequences fetch, decode, execute, memory and writeback, and decodes Opcode/Funct into datapath enables, mux selects and the ALU operation code. It sits between the instruction register and the datapath/ALU.

Parameters:
STATE_W, 4, width of the state register and of the State debug output

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Opcode  input  6  instruction bits [31:26] from the instruction register
Funct  input  6  instruction bits [5:0] from the instruction register
Zero  input  1  ALU Zero flag, same cycle as the current ALU operation
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register write enable
RegDst  output  1  register destination select: 0 = rt, 1 = rd
MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = Data
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
PCSrc  output  2  PC source select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
PCEn  output  1  PC write enable, equal to PCWrite | (Branch & Zero)
Control  output  3  ALU operation code
State  output  STATE_W  current state, for debug

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: on a clk edge with reset high, state <= FETCH (0).
  - While reset is high, PCEn, IRWrite, MemWrite and RegWrite are forced to 0.
  - All other outputs follow their FETCH values.
- Output timing: outputs are combinational from the state register only. PCEn additionally depends on Zero, combinationally.
- Unlisted outputs default to 0.
- ALU codes: 010 add, 110 sub, 000 and, 001 or, 111 slt. Code 011 is never emitted.
- Per-state outputs and next state:
  - FETCH(0): ALUSrcA=0, ALUSrcB=01, Control=010, PCSrc=00, IRWrite=1, PCWrite=1. Next: DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, Control=010. Next by Opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH (instruction dropped; PC already +4)
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, Control=010. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, Control from Funct. Next: ALUWB.
    - Funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
    - Any other Funct -> 010.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, Control=110, PCSrc=01, Branch=1. Next: FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, Control=010. Next: ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1. Next: FETCH.
  - Unused encodings (12-15): outputs at defaults, next state FETCH.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Opcode and Funct are sampled in whatever state uses them. The IR is stable after FETCH because IRWrite=1 only in FETCH.
- Reset mid-instruction: the next state is FETCH regardless of the current state. There are no partial writes in the reset cycle.

Optional Feature:
BNE_EN
- Defined:
  - Opcode 000101 (bne) in DECODE -> state BNE(12).
  - BNE(12) outputs match BRANCH, except PCEn = PCWrite | (BranchNE & ~Zero). Next: FETCH.
- Undefined: 000101 is treated as an illegal opcode (DECODE -> FETCH) and state 12 is unused.

Test Plan:
- reset=1 held for 2 cycles mid-EXECUTE -> State=0 after the edge; RegWrite, MemWrite, IRWrite and PCEn all 0 while reset is high.
- Opcode=100011 -> State sequence 0,1,2,3,4,0; MEMWB has RegWrite=1, MemtoReg=1, RegDst=0; MEMRD has IorD=1.
- Opcode=000000 with Funct 100010, 100101 and 101010 -> in EXECUTE, Control=110, 001 and 111 respectively; ALUWB has RegWrite=1, RegDst=1.
- Opcode=000100 with Zero=1, then with Zero=0 -> in BRANCH, PCEn=1 / 0, Control=110, PCSrc=01.
- Opcode=000010 -> State 0,1,11,0; in JUMP, PCSrc=10, PCEn=1. Opcode=111111 -> State 0,1,0 with no writes in the decode cycle.
- Opcode=000101 with BNE_EN defined and Zero=0 -> State 12, PCEn=1. Without BNE_EN -> State 0,1,0.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control: Moore FSM main controller for the multi-cycle MIPS
// datapath. Optional BNE_EN macro adds the bne instruction (state 12).
// Revision: 1.0
// ============================================================================
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic [2:0]         Control,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11),
    BNE     = STATE_W'(12)
  } state_t;

  state_t     state_q, state_d, out_s;
  logic       mem_write, ir_write, reg_write, pc_write, branch, branch_ne;
  logic [2:0] funct_ctl;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Opcode)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = EXECUTE;
          6'b000100:            state_d = BRANCH;
          6'b001000:            state_d = ADDIEX;
          6'b000010:            state_d = JUMP;
`ifdef BNE_EN
          6'b000101:            state_d = BNE;
`endif
          default:              state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (Opcode == 6'b101011) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    case (Funct)
      6'b100010: funct_ctl = 3'b110;
      6'b100100: funct_ctl = 3'b000;
      6'b100101: funct_ctl = 3'b001;
      6'b101010: funct_ctl = 3'b111;
      default:   funct_ctl = 3'b010;
    endcase
  end

  // During reset the outputs show FETCH values; write strobes are masked below.
  assign out_s = reset ? FETCH : state_q;

  always_comb begin
    IorD      = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    reg_write = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    pc_write  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    Control   = 3'b000;
    case (out_s)
      FETCH:   begin ALUSrcB = 2'b01; Control = 3'b010; ir_write = 1'b1; pc_write = 1'b1; end
      DECODE:  begin ALUSrcB = 2'b11; Control = 3'b010; end
      MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; Control = 3'b010; end
      MEMRD:   IorD = 1'b1;
      MEMWB:   begin MemtoReg = 1'b1; reg_write = 1'b1; end
      MEMWR:   begin IorD = 1'b1; mem_write = 1'b1; end
      EXECUTE: begin ALUSrcA = 1'b1; Control = funct_ctl; end
      ALUWB:   begin RegDst = 1'b1; reg_write = 1'b1; end
      BRANCH:  begin ALUSrcA = 1'b1; Control = 3'b110; PCSrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; Control = 3'b010; end
      ADDIWB:  reg_write = 1'b1;
      JUMP:    begin PCSrc = 2'b10; pc_write = 1'b1; end
`ifdef BNE_EN
      BNE:     begin ALUSrcA = 1'b1; Control = 3'b110; PCSrc = 2'b01; branch_ne = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign PCEn     = (pc_write | (branch & Zero) | (branch_ne & ~Zero)) & ~reset;
  assign State    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Testbench for multicycle_control: directed scenarios plus randomized
// instruction streams checked against a table-driven reference model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] Control;
  logic [3:0] State;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .Control(Control),
    .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BNE = 6'b000101;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z);
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    #1;
  endtask

  function automatic logic [14:0] observed();
    return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, PCSrc, PCEn, Control};
  endfunction

  // Reference model: ALU code from the R-type function table
  function automatic logic [2:0] model_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Reference model: per-state output table from the instruction step list
  function automatic logic [14:0] model_out(input int st, input logic [5:0] fn, input logic z);
    logic       iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0, pcen = 0;
    logic [1:0] asb = 0, pcs = 0;
    logic [2:0] ctl = 0;
    case (st)
      0:  begin asb = 2'b01; ctl = 3'b010; irw = 1; pcen = 1; end
      1:  begin asb = 2'b11; ctl = 3'b010; end
      2:  begin asa = 1; asb = 2'b10; ctl = 3'b010; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; ctl = model_alu(fn); end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; ctl = 3'b110; pcs = 2'b01; pcen = z; end
      9:  begin asa = 1; asb = 2'b10; ctl = 3'b010; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      12: begin asa = 1; ctl = 3'b110; pcs = 2'b01; pcen = ~z; end
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, asa, asb, pcs, pcen, ctl};
  endfunction

  // Reference model: the list of states an instruction walks through
  function automatic void model_path(input logic [5:0] op, output int p[$]);
    case (op)
      OP_LW:   p = '{0, 1, 2, 3, 4};
      OP_SW:   p = '{0, 1, 2, 5};
      OP_R:    p = '{0, 1, 6, 7};
      OP_BEQ:  p = '{0, 1, 8};
      OP_ADDI: p = '{0, 1, 9, 10};
      OP_J:    p = '{0, 1, 11};
`ifdef BNE_EN
      OP_BNE:  p = '{0, 1, 12};
`endif
      default: p = '{0, 1};
    endcase
  endfunction

  task automatic test_reset();
    reset = 1;
    set_in(OP_R, 6'b100000, 1'b1);
    step(); step();
    n_tests++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", State); end
    n_tests++;
    if ({RegWrite, MemWrite, IRWrite, PCEn} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {RegWrite, MemWrite, IRWrite, PCEn});
    end
    reset = 0;
    step(); step();
    n_tests++;
    if (State !== 4'd6) begin n_fail++; $display("FAIL reset_reach_exec: got %0d want 6", State); end
    reset = 1;
    #1;
    n_tests++;
    if ({RegWrite, MemWrite, IRWrite, PCEn} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_exec_strobes: got %b want 0000", {RegWrite, MemWrite, IRWrite, PCEn});
    end
    n_tests++;
    if ({ALUSrcA, ALUSrcB, Control} !== {1'b0, 2'b01, 3'b010}) begin
      n_fail++; $display("FAIL reset_fetch_values: got %b want 001010", {ALUSrcA, ALUSrcB, Control});
    end
    step();
    n_tests++;
    if (State !== 4'd0 || {RegWrite, MemWrite, IRWrite, PCEn} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_after_edge: state %0d strobes %b want 0 0000", State,
                         {RegWrite, MemWrite, IRWrite, PCEn});
    end
    step();
    reset = 0;
    #1;
    n_tests++;
    if (State !== 4'd0 || IRWrite !== 1'b1 || PCEn !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: state %0d IRWrite %b PCEn %b want 0 1 1", State, IRWrite, PCEn);
    end
  endtask

  task automatic test_lw();
    int exp_st[$] = '{0, 1, 2, 3, 4, 0};
    set_in(OP_LW, 6'($urandom), 1'b0);
    foreach (exp_st[k]) begin
      n_tests++;
      if (State !== 4'(exp_st[k])) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", k, State, exp_st[k]); end
      if (k == 3) begin
        n_tests++;
        if (IorD !== 1'b1) begin n_fail++; $display("FAIL lw_memrd_iord: got %b want 1", IorD); end
      end
      if (k == 4) begin
        n_tests++;
        if ({RegWrite, MemtoReg, RegDst} !== 3'b110) begin
          n_fail++; $display("FAIL lw_memwb: got %b want 110", {RegWrite, MemtoReg, RegDst});
        end
      end
      if (k < 5) step();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns  [3] = '{6'b100010, 6'b100101, 6'b101010};
    logic [2:0] ctls [3] = '{3'b110, 3'b001, 3'b111};
    for (int i = 0; i < 3; i++) begin
      set_in(OP_R, fns[i], 1'b0);
      step(); step();
      n_tests++;
      if (State !== 4'd6 || Control !== ctls[i]) begin
        n_fail++; $display("FAIL rtype_exec[%0d]: state %0d ctl %b want 6 %b", i, State, Control, ctls[i]);
      end
      step();
      n_tests++;
      if (State !== 4'd7 || RegWrite !== 1'b1 || RegDst !== 1'b1) begin
        n_fail++; $display("FAIL rtype_aluwb[%0d]: state %0d RegWrite %b RegDst %b want 7 1 1", i, State, RegWrite, RegDst);
      end
      step();
      n_tests++;
      if (State !== 4'd0) begin n_fail++; $display("FAIL rtype_return[%0d]: got %0d want 0", i, State); end
    end
  endtask

  task automatic test_beq();
    for (int i = 0; i < 2; i++) begin
      logic z = (i == 0);
      set_in(OP_BEQ, 6'd0, z);
      step(); step();
      n_tests++;
      if (State !== 4'd8 || PCEn !== z || Control !== 3'b110 || PCSrc !== 2'b01) begin
        n_fail++; $display("FAIL beq[%0d]: state %0d PCEn %b ctl %b PCSrc %b want 8 %b 110 01",
                           i, State, PCEn, Control, PCSrc, z);
      end
      Zero = ~z;
      #1;
      n_tests++;
      if (PCEn !== ~z) begin n_fail++; $display("FAIL beq_zero_comb[%0d]: got %b want %b", i, PCEn, ~z); end
      step();
      n_tests++;
      if (State !== 4'd0) begin n_fail++; $display("FAIL beq_return[%0d]: got %0d want 0", i, State); end
    end
  endtask

  task automatic test_jump_illegal();
    set_in(OP_J, 6'd0, 1'b0);
    step(); step();
    n_tests++;
    if (State !== 4'd11 || PCSrc !== 2'b10 || PCEn !== 1'b1) begin
      n_fail++; $display("FAIL jump: state %0d PCSrc %b PCEn %b want 11 10 1", State, PCSrc, PCEn);
    end
    step();
    n_tests++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL jump_return: got %0d want 0", State); end
    set_in(6'b111111, 6'd0, 1'b1);
    step();
    n_tests++;
    if (State !== 4'd1 || {RegWrite, MemWrite, IRWrite, PCEn} !== 4'b0000) begin
      n_fail++; $display("FAIL illegal_decode: state %0d strobes %b want 1 0000", State,
                         {RegWrite, MemWrite, IRWrite, PCEn});
    end
    step();
    n_tests++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL illegal_return: got %0d want 0", State); end
  endtask

  task automatic test_bne();
    set_in(OP_BNE, 6'd0, 1'b0);
    step(); step();
`ifdef BNE_EN
    n_tests++;
    if (State !== 4'd12 || PCEn !== 1'b1 || PCSrc !== 2'b01 || Control !== 3'b110) begin
      n_fail++; $display("FAIL bne: state %0d PCEn %b PCSrc %b ctl %b want 12 1 01 110", State, PCEn, PCSrc, Control);
    end
    Zero = 1'b1;
    #1;
    n_tests++;
    if (PCEn !== 1'b0) begin n_fail++; $display("FAIL bne_zero_taken: got %b want 0", PCEn); end
    step();
`endif
    n_tests++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL bne_state: got %0d want 0", State); end
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J, OP_BNE};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, fn;
      int         p[$];
      int         idx = $urandom_range(0, 7);
      if (idx < 7) op = ops[idx];
      else begin
        op = 6'($urandom);
        while (op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ || op == OP_ADDI ||
               op == OP_J || op == OP_BNE)
          op = 6'($urandom);
      end
      fn = ($urandom_range(0, 1) == 1) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      model_path(op, p);
      foreach (p[k]) begin
        logic [14:0] want;
        set_in(op, fn, 1'($urandom));
        want = model_out(p[k], fn, Zero);
        n_tests++;
        if (State !== 4'(p[k]) || observed() !== want) begin
          n_fail++; $display("FAIL rand[%0d] op %b step %0d: state %0d outs %b want state %0d outs %b",
                             n, op, k, State, observed(), p[k], want);
        end
        step();
      end
    end
    n_tests++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL rand_end_state: got %0d want 0", State); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_jump_illegal();
    test_bne();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
